// File: rtl/shader_pkg.sv
// shader_pkg: shared ALU constants and request struct for shader-core ALU clients.
package shader_pkg;
  localparam int DATA_W   = 32;
  localparam int ALU_OP_W = 3;
  localparam int NZP_W    = 3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHL = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHR = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MOV = 3'b111;
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } alu_req_t;
endpackage

// File: rtl/alu.sv
// alu: combinational shader-core ALU with {n,z,p} result flags.
module alu
  import shader_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   val_a,
  input  logic [DATA_W-1:0]   val_b,
  output logic [DATA_W-1:0]   result,
  output logic [NZP_W-1:0]    nzp
);
  always_comb begin
    result = op == ALU_OP_ADD ? val_a + val_b :
             op == ALU_OP_SUB ? val_a - val_b :
             op == ALU_OP_AND ? val_a & val_b :
             op == ALU_OP_OR  ? val_a | val_b :
             op == ALU_OP_XOR ? val_a ^ val_b :
             op == ALU_OP_SHL ? val_a << val_b[4:0] :
             op == ALU_OP_SHR ? val_a >> val_b[4:0] : val_b;
    nzp = {result[DATA_W-1], result == '0, !result[DATA_W-1] && result != '0};
  end
endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit scanning from ptr upward with wrap.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [ID_W-1:0] off;
  logic [ID_W:0]  sum;
  logic           found;
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    off   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = ID_W'(k);
        found = 1'b1;
      end
    end
    sum    = {1'b0, ptr} + {1'b0, off};
    gnt_id = ID_W'(sum >= (ID_W + 1)'(N) ? sum - (ID_W + 1)'(N) : sum);
    gnt    = found ? N'(1) << gnt_id : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one alu among NUM_REQ requesters,
// with a registered issue stage (S1) and registered response stage (S2).
module alu_arbiter
  import shader_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][ALU_OP_W-1:0]   req_op,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_b,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]      req_tag,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_W-1:0]                  rsp_result,
  output logic [NZP_W-1:0]                   rsp_nzp,
  output logic [TAG_W-1:0]                   rsp_tag,
  output logic                               busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               xfer;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  alu_req_t           s1_req_q, s1_req_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic               s2_valid_q;
  logic [ID_W-1:0]    s2_id_q;
  logic [DATA_W-1:0]  s2_result_q;
  logic [NZP_W-1:0]   s2_nzp_q;
  logic [TAG_W-1:0]   s2_tag_q;
  logic [DATA_W-1:0]  alu_result;
  logic [NZP_W-1:0]   alu_nzp;
  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );
  alu u_alu (
    .op     (s1_req_q.op),
    .val_a  (s1_req_q.a),
    .val_b  (s1_req_q.b),
    .result (alu_result),
    .nzp    (alu_nzp)
  );
  // Grants are suppressed during reset so no request is consumed and lost.
  always_comb begin
    req_ready  = rst ? '0 : gnt;
    xfer       = |req_ready;
    ptr_d      = xfer ? (gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1) : ptr_q;
    s1_valid_d = xfer;
    s1_id_d    = xfer ? gnt_id : s1_id_q;
    s1_req_d   = xfer ? '{op: req_op[gnt_id], a: req_a[gnt_id], b: req_b[gnt_id]} : s1_req_q;
    s1_tag_d   = xfer ? req_tag[gnt_id] : s1_tag_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_req_q    <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_id_q     <= '0;
      s2_result_q <= '0;
      s2_nzp_q    <= '0;
      s2_tag_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_req_q    <= s1_req_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s1_valid_q;
      s2_id_q     <= s1_id_q;
      s2_result_q <= alu_result;
      s2_nzp_q    <= alu_nzp;
      s2_tag_q    <= s1_tag_q;
    end
  end
  always_comb begin
    rsp_valid  = s2_valid_q ? NUM_REQ'(1) << s2_id_q : '0;
    rsp_result = s2_result_q;
    rsp_nzp    = s2_nzp_q;
    rsp_tag    = s2_tag_q;
    busy       = s1_valid_q | s2_valid_q;
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_alu_arbiter;
  import shader_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]        req_valid = '0;
  logic [3:0]        req_ready;
  logic [3:0][2:0]   req_op = '0;
  logic [3:0][31:0]  req_a = '0;
  logic [3:0][31:0]  req_b = '0;
  logic [3:0][3:0]   req_tag = '0;
  logic [3:0]        rsp_valid;
  logic [31:0]       rsp_result;
  logic [2:0]        rsp_nzp;
  logic [3:0]        rsp_tag;
  logic              busy;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {
    int         cyc;
    logic [3:0] oh;
    logic [31:0] res;
    logic [2:0] nzp;
    logic [3:0] tag;
  } exp_t;
  exp_t q[$];
  alu_arbiter #(.NUM_REQ(4), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_nzp    (rsp_nzp),
    .rsp_tag    (rsp_tag),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    logic eb;
    eb = 1'b0;
    foreach (q[i]) if (q[i].cyc == cyc || q[i].cyc == cyc + 1) eb = 1'b1;
    chk("busy", 32'(busy), 32'(eb));
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(e.oh));
      chk("rsp_result", rsp_result, e.res);
      chk("rsp_nzp", 32'(rsp_nzp), 32'(e.nzp));
      chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'h0);
    end
  end
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    req_op[i]  = ALU_OP_ADD;
    req_a[i]   = a;
    req_b[i]   = b;
    req_tag[i] = tag;
  endtask
  task automatic step(input logic [3:0] v, input int g, input logic [31:0] r, input logic [2:0] n);
    exp_t e;
    req_valid = v;
    #1;
    chk("grant", 32'(req_ready), g < 0 ? 32'h0 : 32'(4'b1 << g));
    if (g >= 0) begin
      e.cyc = cyc + 2;
      e.oh  = 4'b1 << g;
      e.res = r;
      e.nzp = n;
      e.tag = req_tag[g];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 4; i++) set_req(i, 32'(i * 16 + 1), 32'd2, 4'(i + 8));
    @(posedge clk);
    #1;
    repeat (2) step(4'hF, -1, 0, 0);
    rst = 1'b0;
    chk("reset_result", rsp_result, 32'h0);
    chk("reset_nzp", 32'(rsp_nzp), 32'h0);
    chk("reset_tag", 32'(rsp_tag), 32'h0);
    for (int k = 0; k < 8; k++) step(4'hF, k % 4, 32'((k % 4) * 16 + 3), 3'b001);
    set_req(1, 32'd5, 32'd7, 4'd3);
    step(4'b0010, 1, 32'd12, 3'b001);
    repeat (3) step(4'b0000, -1, 0, 0);
    set_req(0, 32'd40, 32'd2, 4'd4);
    set_req(3, 32'd30, 32'd3, 4'd5);
    step(4'b1001, 3, 32'd33, 3'b001);
    step(4'b0001, 0, 32'd42, 3'b001);
    set_req(1, 32'd0, 32'd0, 4'd7);
    step(4'b0010, 1, 32'd0, 3'b010);
    set_req(1, 32'd5, 32'hFFFF_FFF8, 4'd9);
    step(4'b0010, 1, 32'hFFFF_FFFD, 3'b100);
    step(4'b1000, 3, 32'd33, 3'b001);
    set_req(0, 32'd100, 32'd1, 4'd1);
    set_req(2, 32'h7000_0000, 32'h10, 4'd6);
    step(4'b0101, 0, 32'd101, 3'b001);
    set_req(0, 32'd200, 32'd2, 4'd2);
    set_req(1, 32'hDEAD_BEEF, 32'h1234, 4'hF);
    set_req(3, 32'hCAFE_0000, 32'h55, 4'hE);
    step(4'b0101, 2, 32'h7000_0010, 3'b001);
    step(4'b0001, 0, 32'd202, 3'b001);
    repeat (2) step(4'b0000, -1, 0, 0);
    set_req(2, 32'd1, 32'd1, 4'd11);
    step(4'b0100, 2, 32'd2, 3'b001);
    rst = 1'b1;
    step(4'hF, -1, 0, 0);
    q.delete();
    rst = 1'b0;
    set_req(0, 32'd9, 32'd9, 4'd12);
    step(4'hF, 0, 32'd18, 3'b001);
    repeat (4) step(4'b0000, -1, 0, 0);
    chk("drain", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one shader-core `alu` instance among `NUM_REQ` requesters (lanes and the address-generation unit) using round-robin arbitration and a valid/ready request handshake. It grants at most one request per cycle and registers the operands into an issue stage. It then registers the ALU result and routes it back to the winning requester with a one-hot response strobe. It sits between the shader-core issue logic and the combinational `alu`, replacing direct per-user ALU wiring.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2–8.
- `TAG_W`, 4: width of the opaque per-request tag returned with the result.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  requester i has an operation pending.
- `req_ready`  out  NUM_REQ  one-hot or zero; high for the requester granted this cycle.
- `req_op`  in  NUM_REQ×3  ALU op per requester; passed to `alu.op` unmodified.
- `req_a`, `req_b`  in  NUM_REQ×32 each  operands; drive `alu.val_a` and `alu.val_b`.
- `req_tag`  in  NUM_REQ×TAG_W  tag echoed on the response.
- `rsp_valid`  out  NUM_REQ  one-hot strobe; a single cycle per completed request.
- `rsp_result`  out  32  ALU result, shared bus.
- `rsp_nzp`  out  3  ALU `nzp` flags {n,z,p}, shared bus.
- `rsp_tag`  out  TAG_W  tag of the completed request.
- `busy`  out  1  high while the issue or response stage holds a valid entry.

## Operation
- **Transfer rule:** a request transfers when `req_valid[i] && req_ready[i]`.
- **Grant rule:** `req_ready` is combinational from `req_valid` and the priority pointer `ptr`.
  - Granted requester = first i with `req_valid[i]`, scanning ptr, ptr+1, … modulo NUM_REQ.
  - `req_ready` is never asserted to a requester whose `req_valid` is low.
  - Requesters must hold valid, op, operands and tag stable until ready. Dropping valid before a grant is permitted and loses nothing.
- **Pointer update:** on a transfer from requester g, `ptr <= (g+1) mod NUM_REQ`. With no transfer, `ptr` holds.
- **Issue stage (S1) captures:** `{valid, id=g, op, a, b, tag}` on the transfer. S1.valid <= 0 when there is no transfer. The ALU is fed combinationally from S1.
- **Response stage (S2) captures:**
  - `{valid, id, result, nzp, tag}` from S1 and the ALU outputs every cycle.
  - `rsp_valid = S2.valid ? (1 << S2.id) : 0`.
- **Backpressure:** responses have none; each requester must accept `rsp_valid` in the cycle it is asserted.
- **Widths:** arithmetic and flag semantics belong entirely to `alu`; no widening or truncation here. `id` is `$clog2(NUM_REQ)` bits.
- **Reset:**
  - `ptr=0`, S1.valid=0, S2.valid=0.
  - All outputs: `req_ready=0` (during reset), `rsp_valid=0`, `rsp_result=0`, `rsp_nzp=0`, `rsp_tag=0`, `busy=0`.
  - The S1 and S2 data fields are also cleared.
- **Reset mid-operation:** in-flight entries in S1 and S2 are discarded and no response is emitted. Requesters must reissue.

## Timing
- Accept in cycle N → `rsp_valid` high in cycle N+2, for exactly one cycle.
- Throughput: one request per cycle sustained; no bubble between back-to-back grants, including repeated grants to the same requester.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…. Maximum wait is NUM_REQ-1 cycles after valid rises.
- Lone requester: a single valid requester is granted every cycle, whatever the value of `ptr`.
- `busy` is high in cycles N+1 and N+2 for each accept.
- `req_ready` is low in any cycle `rst` is high.

## Structure
- Shared package `shader_pkg` holds:
  - constants `DATA_W=32`, `ALU_OP_W=3`, `NZP_W=3`, and `ALU_OP_ADD=3'b000`;
  - packed struct typedef `alu_req_t {op, a, b}`, reused by other `alu` clients.
- One sub-module: `rr_pick`, a combinational round-robin priority picker. Inputs are `req[NUM_REQ]` and `ptr`; outputs are the one-hot `gnt` and the encoded `gnt_id`.
- The existing `alu` is instantiated once, unmodified.

## Test plan
- **Single request:**
  - Stimulus: requester 1, op `ALU_OP_ADD`, a=5, b=7, tag=3, accepted in cycle N.
  - Required: `rsp_valid=4'b0010`, `rsp_result=12`, `rsp_nzp=3'b001`, `rsp_tag=3` in cycle N+2; all other cycles `rsp_valid=0`.
- **Full contention:**
  - Stimulus: all 4 valid for 8 cycles after reset.
  - Required: grant order 0,1,2,3,0,1,2,3, and responses in the same order two cycles later.
- **Pointer skip:**
  - Stimulus: after a grant to requester 1, requesters 0 and 3 become valid together.
  - Required: 3 granted first, then 0.
- **Zero result flags:**
  - Stimulus: add a=0, b=0.
  - Required: `rsp_result=0`, `rsp_nzp=3'b010`.
  - Also check a negative sum, which must give `rsp_nzp=3'b100`.
- **Reset mid-flight:**
  - Stimulus: accept in cycle N, assert `rst` in cycle N+1.
  - Required: no `rsp_valid` in N+2; `busy=0`; the next grant goes to requester 0.
- **Hold stability:**
  - Stimulus: requester 2 held valid with changing values on other inputs while requester 0 holds the grant.
  - Required: the captured operands and tag match requester 2's stable values when it is granted.
